mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the round-robin memory port arbiter.
package mem_arbiter_pkg;

  // Arbiter state encoding
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Read data returned to a master whose transfer was forced complete
  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEADBEEF;

  // Native memory request payload forwarded downstream
  typedef struct packed {
    logic        instr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] addr;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after last_grant+1 (mod NUM_MASTERS).
module mem_arbiter_rr_pick #(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] last_grant,
  output logic                           found,
  output logic [$clog2(NUM_MASTERS)-1:0] next_grant
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned SUM_W = IDX_W + 2;

  logic [IDX_W:0]         start;
  logic [NUM_MASTERS-1:0] rot;
  logic [IDX_W-1:0]       pos;
  logic [SUM_W-1:0]       sum;

  // Rotate the request vector so last_grant+1 sits at bit 0, then take the lowest set bit
  always_comb begin
    start = {1'b0, last_grant} + (IDX_W + 1)'(1);
    rot   = NUM_MASTERS'({req, req} >> start);
    pos   = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = IDX_W'(i);
      end
    end
    sum = SUM_W'(start) + SUM_W'(pos);
    if (sum >= SUM_W'(NUM_MASTERS)) begin
      sum = sum - SUM_W'(NUM_MASTERS);
    end
    found      = |req;
    next_grant = IDX_W'(sum);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one picorv32-native memory port among NUM_MASTERS
// requesters, one outstanding transfer at a time, with a mandatory idle bubble
// between transfers. Optional forced completion with MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_MASTERS-1:0]    m_valid,
  output logic [NUM_MASTERS-1:0]    m_ready,
  input  logic [NUM_MASTERS-1:0]    m_instr,
  input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  output logic [31:0]               m_rdata,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic                      s_instr,
  output logic [3:0]                s_wstrb,
  output logic [31:0]               s_wdata,
  output logic [31:0]               s_addr,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  input  logic [31:0]               s_rdata
);

  localparam int unsigned          IDX_W    = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  arb_state_e       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic             found;
  mem_req_t         sel_req;
  mem_req_t         req_q;
  logic             done_c;
  logic             tmo_c;

  mem_arbiter_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_pick (
    .req        (m_valid),
    .last_grant (last_grant),
    .found      (found),
    .next_grant (pick)
  );

  // Payload of the master the picker selected
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (pick == IDX_W'(i)) begin
        sel_req.instr = m_instr[i];
        sel_req.wstrb = m_wstrb[4*i +: 4];
        sel_req.wdata = m_wdata[32*i +: 32];
        sel_req.addr  = m_addr[32*i +: 32];
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // GRANT cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ARB_GRANT) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
      if (tmo_c) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  // Timeout limit is meaningless when forced completion is compiled out
  logic unused_cfg;
  assign unused_cfg = |32'(TIMEOUT_CYCLES);
`endif

  // Transfer completion: downstream ready, or the GRANT time limit expiring
  always_comb begin
    tmo_c = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_c = (state == ARB_GRANT) && !s_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    done_c = (state == ARB_GRANT) && (s_ready || tmo_c);
  end

  assign m_ready = done_c ? (ONE_HOT0 << grant) : '0;
  assign m_rdata = tmo_c ? ARB_TIMEOUT_RDATA : s_rdata;

  // Arbitration FSM: pick in IDLE, hold grant and payload until completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
      s_valid    <= 1'b0;
      req_q      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant   <= pick;
            req_q   <= sel_req;
            s_valid <= 1'b1;
            state   <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (done_c) begin
            last_grant <= grant;
            s_valid    <= 1'b0;
            req_q      <= '0;
            state      <= ARB_IDLE;
          end
        end
        default: begin
          s_valid <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign s_instr = req_q.instr;
  assign s_wstrb = req_q.wstrb;
  assign s_wdata = req_q.wdata;
  assign s_addr  = req_q.addr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: negedge-registered memory model, transaction-level
// arbitration model checked every cycle, plus directed literal checks.
// Build with MEM_ARB_TIMEOUT_EN to exercise forced completion.
module tb_mem_arbiter;

  localparam int NM = 2;
  localparam int TO = 8;

  logic             clk;
  logic             resetn;
  logic [NM-1:0]    m_valid;
  logic [NM-1:0]    m_ready;
  logic [NM-1:0]    m_instr;
  logic [4*NM-1:0]  m_wstrb;
  logic [32*NM-1:0] m_wdata;
  logic [32*NM-1:0] m_addr;
  logic [31:0]      m_rdata;
  logic             s_valid;
  logic             s_ready;
  logic             s_instr;
  logic [3:0]       s_wstrb;
  logic [31:0]      s_wdata;
  logic [31:0]      s_addr;
  logic [31:0]      s_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic             timeout_err;
`endif

  mem_arbiter #(
    .NUM_MASTERS    (NM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_instr     (m_instr),
    .m_wstrb     (m_wstrb),
    .m_wdata     (m_wdata),
    .m_addr      (m_addr),
    .m_rdata     (m_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_instr     (s_instr),
    .s_wstrb     (s_wstrb),
    .s_wdata     (s_wdata),
    .s_addr      (s_addr),
`ifdef MEM_ARB_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .s_rdata     (s_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: registers ready on negedge, clears it on the negedge after s_valid drops
  logic [31:0] mem [0:63];
  logic [31:0] mword;
  logic        mem_stall;
  int          mem_wait;
  int          wait_cnt;

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      s_ready  <= 1'b0;
      s_rdata  <= 32'h0;
      wait_cnt = 0;
    end else if (s_valid && !s_ready && !mem_stall) begin
      if (wait_cnt < mem_wait) begin
        wait_cnt = wait_cnt + 1;
      end else begin
        wait_cnt = 0;
        mword = mem[s_addr[7:2]];
        for (int b = 0; b < 4; b++) begin
          if (s_wstrb[b]) mword[8*b +: 8] = s_wdata[8*b +: 8];
        end
        mem[s_addr[7:2]] = mword;
        s_rdata <= mword;
        s_ready <= 1'b1;
      end
    end else begin
      s_ready <= 1'b0;
    end
  end

  // Transaction-level model of the arbiter
  bit          mbusy;
  bit          mterr;
  int          mlast;
  int          mowner;
  int          mcnt;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mwstrb;
  logic        minstr;
  bit          exp_tmo;
  bit          exp_done;
  bit          mfound;
  int          midx;
  logic [NM-1:0] exp_ready;
  int          done_q[$];
  logic [31:0] rd_q[$];

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_m_ready", 32'(m_ready), 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        mbusy = 0; mterr = 0; mlast = NM - 1; mcnt = 0;
      end else begin
        exp_tmo = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        exp_tmo = mbusy && !s_ready && (mcnt == TO - 1);
        check("mdl_timeout_err", 32'(timeout_err), 32'(mterr));
`endif
        exp_done  = mbusy && (s_ready || exp_tmo);
        exp_ready = exp_done ? NM'(1 << mowner) : '0;
        check("mdl_s_valid", 32'(s_valid), 32'(mbusy));
        check("mdl_m_ready", 32'(m_ready), 32'(exp_ready));
        if (mbusy) begin
          check("mdl_s_addr", s_addr, maddr);
          check("mdl_s_wdata", s_wdata, mwdata);
          check("mdl_s_wstrb", 32'(s_wstrb), 32'(mwstrb));
          check("mdl_s_instr", 32'(s_instr), 32'(minstr));
        end
        if (exp_done) begin
          check("mdl_m_rdata", m_rdata, exp_tmo ? 32'hDEADBEEF : s_rdata);
          done_q.push_back(mowner);
          rd_q.push_back(m_rdata);
        end
        // advance to next cycle
        if (mbusy) begin
          if (exp_done) begin
            mbusy = 0;
            mlast = mowner;
            if (exp_tmo) mterr = 1;
          end else begin
            mcnt++;
          end
        end else if (m_valid != '0) begin
          mfound = 0;
          for (int k = 1; k <= NM; k++) begin
            midx = (mlast + k) % NM;
            if (!mfound && m_valid[midx]) begin
              mfound = 1;
              mowner = midx;
            end
          end
          maddr  = m_addr[32*mowner +: 32];
          mwdata = m_wdata[32*mowner +: 32];
          mwstrb = m_wstrb[4*mowner +: 4];
          minstr = m_instr[mowner];
          mbusy  = 1;
          mcnt   = 0;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] ws,
                         input logic [31:0] wd, input logic ins);
    m_addr[32*i +: 32] = a;
    m_wstrb[4*i +: 4]  = ws;
    m_wdata[32*i +: 32] = wd;
    m_instr[i]          = ins;
    m_valid[i]          = 1'b1;
  endtask

  // Run until n completions are logged; masters drop valid after their ready unless hold
  task automatic run_until(input int n, input int budget, input logic hold);
    int cyc;
    logic [NM-1:0] fin;
    cyc = 0;
    while (done_q.size() < n && cyc < budget) begin
      @(negedge clk); #3;
      fin = m_ready;
      cyc++;
      @(posedge clk); #1;
      if (!hold) m_valid = m_valid & ~fin;
    end
    check("run_until_count", 32'(done_q.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          n_sv;
  int          n_rdy;
  int          exp_order[4];
  logic [31:0] rdv;
  bit          got;

  initial begin
    resetn = 1'b0; m_valid = '0; m_instr = '0; m_wstrb = '0; m_wdata = '0; m_addr = '0;
    mem_stall = 1'b0; mem_wait = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h12345678;
    mem[8] = 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_valid", 32'(s_valid), 32'h0);
    check("reset_m_ready", 32'(m_ready), 32'h0);
    check("reset_s_instr", 32'(s_instr), 32'h0);
    check("reset_s_wstrb", 32'(s_wstrb), 32'h0);
    check("reset_s_wdata", s_wdata, 32'h0);
    check("reset_s_addr", s_addr, 32'h0);
    resetn = 1'b1;

    // single read by master 0
    @(posedge clk); #1;
    set_req(0, 32'h10, 4'h0, 32'h0, 1'b1);
    @(negedge clk); #3;
    check("t1_cycle0_s_valid", 32'(s_valid), 32'h0);
    @(negedge clk); #3;
    check("t1_s_valid", 32'(s_valid), 32'h1);
    check("t1_s_addr", s_addr, 32'h10);
    check("t1_s_instr", 32'(s_instr), 32'h1);
    check("t1_m_ready", 32'(m_ready), 32'h1);
    check("t1_m_rdata", m_rdata, 32'h12345678);
    @(posedge clk); #1;
    m_valid[0] = 1'b0;
    @(negedge clk); #3;
    check("t1_bubble_s_valid", 32'(s_valid), 32'h0);
    check("t1_bubble_m_ready", 32'(m_ready), 32'h0);

    // byte write by master 1, readback by master 0
    @(posedge clk); #1;
    set_req(1, 32'h20, 4'b0100, 32'h00AB0000, 1'b0);
    @(negedge clk); #3;
    @(negedge clk); #3;
    check("t2_s_wstrb", 32'(s_wstrb), 32'h4);
    check("t2_s_wdata", s_wdata, 32'h00AB0000);
    check("t2_s_addr", s_addr, 32'h20);
    check("t2_m_ready", 32'(m_ready), 32'h2);
    @(posedge clk); #1;
    m_valid[1] = 1'b0;
    set_req(0, 32'h20, 4'h0, 32'h0, 1'b0);
    done_q.delete(); rd_q.delete();
    run_until(1, 20, 1'b0);
    if (rd_q.size() > 0) begin
      check("t2_readback_word", rd_q[0], 32'h11AB3344);
      check("t2_readback_byte2", 32'(rd_q[0][23:16]), 32'hAB);
      check("t2_reader", 32'(done_q[0]), 32'h0);
    end

    // reset during GRANT
    mem_stall = 1'b1;
    @(posedge clk); #1;
    set_req(1, 32'h44, 4'h0, 32'h0, 1'b0);
    @(negedge clk); #3;
    @(negedge clk); #3;
    check("t3_granted", 32'(s_valid), 32'h1);
    check("t3_granted_addr", s_addr, 32'h44);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("t3_async_s_valid", 32'(s_valid), 32'h0);
    check("t3_async_m_ready", 32'(m_ready), 32'h0);
    m_valid = '0; mem_stall = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // contention: both masters request continuously
    done_q.delete();
    @(posedge clk); #1;
    set_req(0, 32'h0, 4'h0, 32'h0, 1'b0);
    set_req(1, 32'h4, 4'hF, 32'hCAFEF00D, 1'b0);
    run_until(4, 40, 1'b1);
    m_valid = '0;
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < done_q.size() && i < 4; i++) begin
      check("t4_grant_order", 32'(done_q[i]), 32'(exp_order[i]));
    end

    // late arrival of master 1 during master 0's transfer
    mem_wait = 2;
    done_q.delete();
    @(posedge clk); #1;
    set_req(0, 32'h30, 4'h0, 32'h0, 1'b0);
    @(negedge clk); #3;
    @(negedge clk); #3;
    check("t5_m0_addr", s_addr, 32'h30);
    @(posedge clk); #1;
    set_req(1, 32'h40, 4'h0, 32'h0, 1'b0);
    @(negedge clk); #3;
    check("t5_addr_held", s_addr, 32'h30);
    check("t5_wait_no_ready", 32'(m_ready), 32'h0);
    run_until(2, 30, 1'b0);
    if (done_q.size() == 2) begin
      check("t5_first", 32'(done_q[0]), 32'h0);
      check("t5_second", 32'(done_q[1]), 32'h1);
    end
    mem_wait = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // forced completion when memory never answers
    check("t6_err_clear", 32'(timeout_err), 32'h0);
    mem_stall = 1'b1;
    @(posedge clk); #1;
    set_req(0, 32'h50, 4'h0, 32'h0, 1'b0);
    n_sv = 0; got = 0; rdv = 32'h0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk); #3;
      if (s_valid) n_sv++;
      if (m_ready[0]) begin
        got = 1;
        rdv = m_rdata;
      end
    end
    check("t6_timeout_seen", 32'(got), 32'h1);
    check("t6_grant_cycles", 32'(n_sv), 32'(TO));
    check("t6_rdata", rdv, 32'hDEADBEEF);
    @(posedge clk); #1;
    m_valid = '0; mem_stall = 1'b0;
    @(negedge clk); #3;
    check("t6_err_set", 32'(timeout_err), 32'h1);
    done_q.delete();
    @(posedge clk); #1;
    set_req(1, 32'h60, 4'h0, 32'h0, 1'b0);
    run_until(1, 20, 1'b0);
    check("t6_err_sticky", 32'(timeout_err), 32'h1);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("t6_err_reset", 32'(timeout_err), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
`else
    // without forced completion a stalled memory holds the grant indefinitely
    mem_stall = 1'b1;
    @(posedge clk); #1;
    set_req(0, 32'h50, 4'h0, 32'h0, 1'b0);
    n_sv = 0; n_rdy = 0;
    repeat (20) begin
      @(negedge clk); #3;
      if (s_valid) n_sv++;
      if (m_ready != '0) n_rdy++;
    end
    check("t6_stall_grant_cycles", 32'(n_sv), 32'd19);
    check("t6_stall_no_ready", 32'(n_rdy), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b0;
    m_valid = '0; mem_stall = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
